// File: rtl/silife_load_pkg.sv
// silife load chain driver shared types.
// FSM states and divider limits.
package silife_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOW,
    HIGH,
    TAIL
  } state_t;

  localparam int MIN_CLK_DIV = 1;

endpackage

// File: rtl/silife_clk_div_tick.sv
// Phase timer for the load clock generator.
// Reloads to DIV-1 and flags the last cycle of each timed phase.
module silife_clk_div_tick
  import silife_load_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int D = (DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : DIV;
  localparam int W = (D > 1) ? $clog2(D) : 1;
  localparam logic [W-1:0] TOP = W'(D - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TOP;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/silife_load_driver.sv
// Transmit end of the silife serial load chain.
// Serialises a framed word stream MSB first onto cs/clk/data.
module silife_load_driver
  import silife_load_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_frame_words,
  input  logic              i_abort,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_load_cs,
  output logic              o_load_clk,
  output logic              o_load_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int DIV = (CLK_DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : CLK_DIV;
  localparam int BW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bit_idx;
  logic [CNT_W-1:0]  words_left;
  logic              timed;
  logic              tick;

  assign timed = (state == LOW) || (state == HIGH) || (state == TAIL);

  // Held loaded outside timed phases so every phase starts fresh.
  silife_clk_div_tick #(
    .DIV (DIV)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (!timed || tick),
    .en      (timed),
    .tick    (tick)
  );

  assign o_load_data = shreg[WORD_W-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      words_left <= '0;
      o_ready    <= 1'b0;
      o_load_cs  <= 1'b0;
      o_load_clk <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state != IDLE && i_abort) begin
        state      <= IDLE;
        shreg      <= '0;
        words_left <= '0;
        o_ready    <= 1'b0;
        o_load_cs  <= 1'b0;
        o_load_clk <= 1'b0;
        o_busy     <= 1'b0;
        o_done     <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (i_start) begin
              if (i_frame_words == '0) begin
                o_done <= 1'b1;
              end else begin
                state      <= FETCH;
                words_left <= i_frame_words;
                o_ready    <= 1'b1;
                o_load_cs  <= 1'b1;
                o_busy     <= 1'b1;
              end
            end
          end
          FETCH: begin
            if (i_valid && o_ready) begin
              shreg      <= i_data;
              words_left <= words_left - 1'b1;
              bit_idx    <= LAST;
              o_ready    <= 1'b0;
              state      <= LOW;
            end
          end
          LOW: begin
            if (tick) begin
              o_load_clk <= 1'b1;
              state      <= HIGH;
            end
          end
          HIGH: begin
            if (tick) begin
              o_load_clk <= 1'b0;
              if (bit_idx != '0) begin
                bit_idx <= bit_idx - 1'b1;
                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                state   <= LOW;
              end else if (words_left != '0) begin
                o_ready <= 1'b1;
                state   <= FETCH;
              end else begin
                state <= TAIL;
              end
            end
          end
          TAIL: begin
            if (tick) begin
              shreg     <= '0;
              o_load_cs <= 1'b0;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_silife_load_driver.sv
// Bench for silife_load_driver: CLK_DIV=2 and CLK_DIV=1 instances.
// Serial stream is checked against words, frame lengths and a tile chain.
module tb_silife_load_driver;

  logic        clk = 1'b0;
  logic        reset_n, sel;
  logic        i_start, i_abort, i_valid;
  logic [15:0] i_frame_words;
  logic [7:0]  i_data;

  logic rst_a, rst_b;
  logic ready_a, cs_a, clk_a, data_a, busy_a, done_a;
  logic ready_b, cs_b, clk_b, data_b, busy_b, done_b;
  logic ready, cs, lclk, ldata, busy, done;

  always #5 clk = ~clk;

  assign rst_a = reset_n & ~sel;
  assign rst_b = reset_n & sel;
  assign ready = sel ? ready_b : ready_a;
  assign cs    = sel ? cs_b    : cs_a;
  assign lclk  = sel ? clk_b   : clk_a;
  assign ldata = sel ? data_b  : data_a;
  assign busy  = sel ? busy_b  : busy_a;
  assign done  = sel ? done_b  : done_a;

  silife_load_driver #(.WORD_W(8), .CLK_DIV(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(rst_a), .i_start(i_start),
    .i_frame_words(i_frame_words), .i_abort(i_abort),
    .i_data(i_data), .i_valid(i_valid), .o_ready(ready_a),
    .o_load_cs(cs_a), .o_load_clk(clk_a), .o_load_data(data_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  silife_load_driver #(.WORD_W(8), .CLK_DIV(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(rst_b), .i_start(i_start),
    .i_frame_words(i_frame_words), .i_abort(i_abort),
    .i_data(i_data), .i_valid(i_valid), .o_ready(ready_b),
    .o_load_cs(cs_b), .o_load_clk(clk_b), .o_load_data(data_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word source: holds valid while words are queued, optional stall.
  logic [7:0] feed_q[$];
  int popped, stall_idx, stall_left;

  always @(posedge clk) begin
    if (reset_n && i_valid && ready && !i_abort && feed_q.size() > 0) begin
      void'(feed_q.pop_front());
      popped++;
    end
  end

  always @(negedge clk) begin
    if (stall_left > 0 && popped == stall_idx && ready) begin
      i_valid = 1'b0;
      stall_left--;
    end else begin
      i_valid = feed_q.size() > 0;
      i_data  = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
    end
  end

  // Line monitor and two-tile chain model clocked by load_clk rises.
  int cyc, cs_cycles, done_cnt, rises, last_rise;
  logic prev_clk, prev_data;
  logic [23:0] chain;
  logic rx_q[$];

  always @(negedge clk) begin
    cyc++;
    if (cs) cs_cycles++;
    if (done) done_cnt++;
    if (lclk) chk("clk_needs_cs", cs, 1);
    if (ready) chk("fetch_clk_low", lclk, 0);
    if (cs && lclk && !prev_clk) begin
      rises++;
      rx_q.push_back(ldata);
      chain = {chain[22:0], ldata};
      chk("data_stable", ldata, prev_data);
      if ((rises - 1) % 8 != 0)
        chk("bit_period", cyc - last_rise, sel ? 2 : 4);
      last_rise = cyc;
    end
    prev_clk  = lclk;
    prev_data = ldata;
  end

  task automatic start_frame(input bit s, input int n,
                             input logic [31:0] w, input int st);
    @(negedge clk);
    sel = s;
    feed_q.delete();
    i_valid = 1'b0;
    @(negedge clk);
    cs_cycles = 0; done_cnt = 0; rises = 0; chain = '0;
    rx_q.delete();
    popped = 0;
    stall_idx = st;
    stall_left = (st >= 0) ? 10 : 0;
    for (int i = 0; i < n; i++) feed_q.push_back(w[31-8*i -: 8]);
    @(negedge clk);
    i_start = 1'b1;
    i_frame_words = 16'(n);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic finish_frame(input int n, input logic [31:0] w,
                              input int exp_cs);
    int k;
    logic [7:0] got;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", k < 3000, 1);
    repeat (3) @(negedge clk);
    chk("cs_cycles", cs_cycles, exp_cs);
    chk("rises", rises, n * 8);
    chk("done_pulses", done_cnt, 1);
    chk("busy_end", busy, 0);
    for (int i = 0; i < n; i++) begin
      got = '0;
      for (int b = 0; b < 8; b++)
        got = {got[6:0], (i*8+b < rx_q.size()) ? rx_q[i*8+b] : 1'bx};
      chk("word", got, w[31-8*i -: 8]);
    end
  endtask

  typedef struct {
    bit          s;
    int          n;
    logic [31:0] w;
    int          st;
    int          cs;
  } vec_t;

  initial begin
    vec_t vt[5];
    int k, n, st, div, s;
    logic [31:0] w;

    vt[0] = '{0, 1, 32'hA5000000, -1, 35};
    vt[1] = '{0, 3, 32'h0180FF00, -1, 101};
    vt[2] = '{0, 2, 32'h3CC30000, 1, 78};
    vt[3] = '{1, 2, 32'h5A960000, -1, 35};
    vt[4] = '{1, 1, 32'h00000000, -1, 18};

    reset_n = 1'b1; sel = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_valid = 1'b0;
    i_frame_words = '0; i_data = '0;
    popped = 0; stall_idx = -1; stall_left = 0;
    cyc = 0; cs_cycles = 0; done_cnt = 0; rises = 0; last_rise = 0;
    prev_clk = 0; prev_data = 0; chain = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cs", cs, 0);
    chk("rst_clk", lclk, 0);
    chk("rst_data", ldata, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      start_frame(vt[i].s, vt[i].n, vt[i].w, vt[i].st);
      finish_frame(vt[i].n, vt[i].w, vt[i].cs);
      if (i == 1) chk("tile_chain", chain, 24'h0180FF);
    end

    // Abort after three bits, then a clean frame restarts at the MSB.
    start_frame(0, 2, 32'hF00F0000, -1);
    k = 0;
    while (rises < 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach", k < 500, 1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_cs", cs, 0);
    chk("abort_clk", lclk, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 0);
    repeat (4) @(negedge clk);
    chk("abort_done_pulses", done_cnt, 1);
    chk("abort_rises", rises, 3);
    start_frame(0, 1, 32'hC5000000, -1);
    finish_frame(1, 32'hC5000000, 35);

    // Asynchronous reset while load_clk is high.
    start_frame(0, 1, 32'hFF000000, -1);
    k = 0;
    while (!lclk && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_high", k < 100, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_cs", cs, 0);
    chk("mid_rst_clk", lclk, 0);
    chk("mid_rst_data", ldata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    feed_q.delete();
    i_valid = 1'b0;
    reset_n = 1'b1;

    // Zero-length frame: done only, chip select never asserted.
    @(negedge clk);
    cs_cycles = 0; done_cnt = 0;
    i_start = 1'b1;
    i_frame_words = '0;
    @(negedge clk);
    i_start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_cs", cs, 0);
    repeat (5) @(negedge clk);
    chk("zero_cs_cycles", cs_cycles, 0);
    chk("zero_done_pulses", done_cnt, 1);

    // Start while busy is ignored (CLK_DIV=1 instance).
    start_frame(1, 1, 32'h69000000, -1);
    repeat (5) @(negedge clk);
    i_start = 1'b1;
    i_frame_words = 16'd3;
    @(negedge clk);
    i_start = 1'b0;
    finish_frame(1, 32'h69000000, 18);
    repeat (20) @(negedge clk);
    chk("busy_start_ignored", cs_cycles, 18);

    // Random frames against the frame-length and bit-order model.
    for (int r = 0; r < 6; r++) begin
      s   = int'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 4));
      w   = $urandom;
      st  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      div = (s == 1) ? 1 : 2;
      start_frame(s[0], n, w, st);
      finish_frame(n, w, n * (1 + 16 * div) + div + ((st >= 0) ? 10 : 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
